// File: rtl/pixel_fsm_pkg.sv
// pixel_fsm_pkg: shared state encoding, default parameters and sizing helpers for the pixel sensor FSM.
package pixel_fsm_pkg;
  typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, READ} state_e;
  localparam int DEF_BIT_DEPTH = 8;
  localparam int DEF_ROWS = 2;
  localparam int DEF_ERASE_CYCLES = 5;
  localparam int DEF_EXPOSE_CYCLES = 255;
  function automatic int conv_cycles(input int bit_depth);
    return 2 * ((1 << bit_depth) - 1);
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return (a > b ? a : b) > c ? (a > b ? a : b) : c;
  endfunction
endpackage

// File: rtl/pixel_sensor_fsm_if.sv
// pixel_sensor_fsm_if: frame request, row handshake and array control signals of the pixel sensor FSM.
interface pixel_sensor_fsm_if #(parameter int ROWS = 2);
  logic START, ROW_ACK;
  logic ERASE, EXPOSE, CONVERT, READ;
  logic [ROWS-1:0] ROW_SELECT;
  logic COUNTER_RESET, COUNTER_CLOCK, FRAME_DONE;
  modport master(input START, ROW_ACK,
                 output ERASE, EXPOSE, CONVERT, READ, ROW_SELECT, COUNTER_RESET, COUNTER_CLOCK, FRAME_DONE);
  modport slave(output START, ROW_ACK,
                input ERASE, EXPOSE, CONVERT, READ, ROW_SELECT, COUNTER_RESET, COUNTER_CLOCK, FRAME_DONE);
endinterface

// File: rtl/pixel_phase_timer.sv
// pixel_phase_timer: loadable down-counter that saturates at zero; done flags the final cycle of a phase.
module pixel_phase_timer #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] value_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? value_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign done_o = cnt_q == '0;
endmodule

// File: rtl/pixel_sensor_fsm.sv
// pixel_sensor_fsm: erase/expose/convert/read frame sequencer; PIXEL_FSM_CONTINUOUS_EN loops READ back into ERASE.
module pixel_sensor_fsm
  import pixel_fsm_pkg::*;
#(
  parameter int BIT_DEPTH = DEF_BIT_DEPTH,
  parameter int ROWS = DEF_ROWS,
  parameter int ERASE_CYCLES = DEF_ERASE_CYCLES,
  parameter int EXPOSE_CYCLES = DEF_EXPOSE_CYCLES
) (
  input logic CLK,
  input logic RESET,
  pixel_sensor_fsm_if.master bus
);
  localparam int CONV = conv_cycles(BIT_DEPTH);
  localparam int TW = $clog2(max3(ERASE_CYCLES, EXPOSE_CYCLES, CONV));
`ifdef PIXEL_FSM_CONTINUOUS_EN
  localparam state_e FRAME_NEXT = ERASE;
`else
  localparam state_e FRAME_NEXT = IDLE;
`endif
  state_e state_q, state_d;
  logic [ROWS-1:0] row_q, row_d;
  logic cclk_q, cclk_d, fd_q, fd_d;
  logic t_load, t_en, t_done;
  logic [TW-1:0] t_val;
  pixel_phase_timer #(.W(TW)) u_timer (
    .clk(CLK), .rst(RESET), .load_i(t_load), .en_i(t_en), .value_i(t_val), .done_o(t_done)
  );
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    fd_d = 1'b0;
    unique case (state_q)
      IDLE:    if (bus.START) state_d = ERASE;
      ERASE:   if (t_done) state_d = EXPOSE;
      EXPOSE:  if (t_done) state_d = CONVERT;
      CONVERT: if (t_done) begin
        state_d = READ;
        row_d = ROWS'(1);
      end
      READ:    if (bus.ROW_ACK) begin
        row_d = row_q << 1;
        fd_d = row_q[ROWS-1];
        state_d = row_q[ROWS-1] ? FRAME_NEXT : READ;
      end
      default: state_d = IDLE;
    endcase
    // counter clock starts low on CONVERT entry and is forced low on exit
    cclk_d = state_d == CONVERT && state_q == CONVERT && !cclk_q;
    t_load = state_d != state_q;
    t_en = state_q == ERASE || state_q == EXPOSE || state_q == CONVERT;
    t_val = state_d == ERASE ? TW'(ERASE_CYCLES - 1) : state_d == EXPOSE ? TW'(EXPOSE_CYCLES - 1) : TW'(CONV - 1);
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state_q <= IDLE;
      row_q <= '0;
      cclk_q <= 1'b0;
      fd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      cclk_q <= cclk_d;
      fd_q <= fd_d;
    end
  assign bus.ERASE = state_q == ERASE;
  assign bus.EXPOSE = state_q == EXPOSE;
  assign bus.CONVERT = state_q == CONVERT;
  assign bus.READ = state_q == READ;
  assign bus.ROW_SELECT = row_q;
  assign bus.COUNTER_RESET = state_q != CONVERT;
  assign bus.COUNTER_CLOCK = cclk_q;
  assign bus.FRAME_DONE = fd_q;
endmodule
